// File: rtl/logic_gates.sv
// logic_gates: registered bitwise two-input gate unit with a valid flag
module logic_gates #(
  parameter int WIDTH = 1
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic [WIDTH-1:0] oAnd,
  output logic [WIDTH-1:0] oOr,
  output logic [WIDTH-1:0] oNot,
  output logic [WIDTH-1:0] oXor,
  output logic [WIDTH-1:0] oNand,
  output logic [WIDTH-1:0] oNor,
  output logic [WIDTH-1:0] oXnor,
  output logic             oValid
);
  // every result is flopped straight from the operands; reset clears all, inverted gates included
  always_ff @(posedge iClk or negedge iRst_n)
    if (!iRst_n) begin
      oAnd   <= '0;
      oOr    <= '0;
      oNot   <= '0;
      oXor   <= '0;
      oNand  <= '0;
      oNor   <= '0;
      oXnor  <= '0;
      oValid <= 1'b0;
    end else begin
      oAnd   <= iA & iB;
      oOr    <= iA | iB;
      oNot   <= ~iA;
      oXor   <= iA ^ iB;
      oNand  <= ~(iA & iB);
      oNor   <= ~(iA | iB);
      oXnor  <= ~(iA ^ iB);
      oValid <= 1'b1;
    end
endmodule

// File: tb/tb_logic_gates.sv
// tb_logic_gates: directed and random checks of logic_gates at WIDTH=1 and WIDTH=8
module tb_logic_gates;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a1, b1;
  logic [7:0] a8, b8;
  logic and1, or1, not1, xor1, nand1, nor1, xnor1, v1;
  logic [7:0] and8, or8, not8, xor8, nand8, nor8, xnor8;
  logic v8;
  logic [55:0] o1, o8;
  int total = 0;
  int bad = 0;
  string nm [7] = '{"xnor", "nor", "nand", "xor", "not", "or", "and"};

  logic_gates #(.WIDTH(1)) dut1 (
    .iClk(clk), .iRst_n(rst_n), .iA(a1), .iB(b1),
    .oAnd(and1), .oOr(or1), .oNot(not1), .oXor(xor1),
    .oNand(nand1), .oNor(nor1), .oXnor(xnor1), .oValid(v1)
  );

  logic_gates #(.WIDTH(8)) dut8 (
    .iClk(clk), .iRst_n(rst_n), .iA(a8), .iB(b8),
    .oAnd(and8), .oOr(or8), .oNot(not8), .oXor(xor8),
    .oNand(nand8), .oNor(nor8), .oXnor(xnor8), .oValid(v8)
  );

  assign o1 = {7'b0, and1, 7'b0, or1, 7'b0, not1, 7'b0, xor1, 7'b0, nand1, 7'b0, nor1, 7'b0, xnor1};
  assign o8 = {and8, or8, not8, xor8, nand8, nor8, xnor8};

  always #5 clk = ~clk;

  // reference: each lane evaluated with integer arithmetic on 0/1 values
  function automatic logic [55:0] gates(input logic [7:0] a, input logic [7:0] b, input int w);
    logic [55:0] r = '0;
    for (int i = 0; i < w; i++) begin
      int x = int'(a[i]);
      int y = int'(b[i]);
      int an = x * y;
      int orr = x + y - x * y;
      int xr = (x + y) % 2;
      r[48 + i] = an[0];
      r[40 + i] = orr[0];
      r[32 + i] = 1'(1 - x);
      r[24 + i] = xr[0];
      r[16 + i] = 1'(1 - an);
      r[8 + i]  = 1'(1 - orr);
      r[i]      = 1'(1 - xr);
    end
    return r;
  endfunction

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic [55:0] obs, input logic [55:0] exp,
                     input logic v, input logic ev);
    for (int k = 0; k < 7; k++) cmp({tag, ".", nm[k]}, obs[8*k +: 8], exp[8*k +: 8]);
    cmp({tag, ".valid"}, {7'b0, v}, {7'b0, ev});
  endtask

  initial begin
    int ta [5] = '{0, 1, 0, 1, 0};
    int tb [5] = '{0, 0, 1, 1, 0};
    a1 = 1'b1; b1 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    repeat (3) @(posedge clk);
    #1 chk("rst1", o1, '0, v1, 1'b0);
    chk("rst8", o8, '0, v8, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 chk("rel1", o1, gates(8'd1, 8'd1, 1), v1, 1'b1);
    chk("rel8", o8, gates(8'hFF, 8'hFF, 8), v8, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a1 = 1'(ta[i]);
      b1 = 1'(tb[i]);
      repeat (4) begin
        @(posedge clk);
        #1 chk($sformatf("tt%0d", i), o1, gates({7'b0, a1}, {7'b0, b1}, 1), v1, 1'b1);
      end
    end
    @(posedge clk);
    #3 a1 = 1'b1;
    #1 chk("lat_hold", o1, gates(8'd0, 8'd0, 1), v1, 1'b1);
    @(posedge clk);
    #1 chk("lat_edge", o1, gates(8'd1, 8'd0, 1), v1, 1'b1);
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; a8 = 8'hF0; b8 = 8'h3C;
    @(posedge clk);
    #1 chk("w8", o8, gates(8'hF0, 8'h3C, 8), v8, 1'b1);
    cmp("w8c.and", and8, 8'h30);
    cmp("w8c.or", or8, 8'hFC);
    cmp("w8c.not", not8, 8'h0F);
    cmp("w8c.xor", xor8, 8'hCC);
    cmp("w8c.nand", nand8, 8'hCF);
    cmp("w8c.nor", nor8, 8'h03);
    cmp("w8c.xnor", xnor8, 8'h33);
    chk("pre_async1", o1, gates(8'd1, 8'd1, 1), v1, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk("async1", o1, '0, v1, 1'b0);
    chk("async8", o8, '0, v8, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      a1 = 1'($urandom_range(1));
      b1 = 1'($urandom_range(1));
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      @(posedge clk);
      #1 chk("rnd1", o1, gates({7'b0, a1}, {7'b0, b1}, 1), v1, 1'b1);
      chk("rnd8", o8, gates(a8, b8, 8), v8, 1'b1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
